// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, expander states, block type and GF(2^8) xtime.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    typedef logic [127:0] block_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational lookup; shared by key expansion and the cipher rounds.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key schedule generator: one round key per cycle into a register file with a registered read port.
module aes_key_expander #(
    parameter int NR = aes_pkg::NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out
);

    import aes_pkg::*;

    state_t      state;
    state_t      state_next;
    block_t      rk [0:NR];
    block_t      prev_key;
    block_t      next_key;
    logic [7:0]  rcon;
    logic [3:0]  round;
    logic        last_round;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] w4, w5, w6, w7;

    assign last_round = (round == 4'(NR));
    assign busy       = (state == EXPAND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)      state_next = EXPAND;
            EXPAND:  if (last_round) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // prev_key mirrors rk[round-1] so the round function never needs a wide read mux.
    assign rot_word = {prev_key[23:0], prev_key[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot_word[8*i +: 8]),
            .dout (sub_word[8*i +: 8])
        );
    end

    assign w4       = prev_key[127:96] ^ sub_word ^ {rcon, 24'h0};
    assign w5       = w4 ^ prev_key[95:64];
    assign w6       = w5 ^ prev_key[63:32];
    assign w7       = w6 ^ prev_key[31:0];
    assign next_key = {w4, w5, w6, w7};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
            prev_key   <= '0;
            rcon       <= 8'h01;
            round      <= '0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk[0]      <= key_in;
                        prev_key   <= key_in;
                        rcon       <= 8'h01;
                        round      <= 4'd1;
                        keys_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk[round] <= next_key;
                    prev_key  <= next_key;
                    rcon      <= xtime(rcon);
                    if (last_round) begin
                        round      <= '0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read port is independent of the FSM; out-of-range indices read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      rk_out <= '0;
        else if (rk_idx <= 4'(NR))    rk_out <= rk[rk_idx];
        else                          rk_out <= '0;
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander against a FIPS-197 reference built from GF(2^8) arithmetic.
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         start;
    logic         busy;
    logic         done;
    logic         keys_valid;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;

    aes_key_expander #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out)
    );

    always #5 clk = ~clk;

    typedef logic [127:0] sched_t [0:10];
    typedef struct {
        logic [127:0] exp;
        int           cyc;
        string        name;
    } rd_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    rd_t        rd_q[$];
    int         done_q[$];
    logic [7:0] m_sbox [256];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            m_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic sched_t model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        sched_t      s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sbox[t[31:24]], m_sbox[t[23:16]], m_sbox[t[15:8]], m_sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start; an accepted start must produce done ten edges after the sampling edge.
    task automatic applyStimulus(input logic [127:0] key, input bit accepted);
        key_in = key;
        start  = 1'b1;
        if (accepted) done_q.push_back(cyc + 1 + 10);
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic read_check(input int idx, input logic [127:0] exp, input string name);
        rd_t r;
        rk_idx = 4'(idx);
        r.exp  = exp;
        r.cyc  = cyc + 1;
        r.name = name;
        rd_q.push_back(r);
        tick();
    endtask

    // Monitor: matches done pulses and registered reads against queued expectations.
    always @(negedge clk) begin
        rd_t r;
        int  e;
        if (done) begin
            if (done_q.size() == 0) begin
                checkOutput("done_unexpected", 128'(done), 128'(0));
            end else begin
                e = done_q.pop_front();
                checkOutput("done_cycle", 128'(cyc), 128'(e));
            end
        end else if (done_q.size() > 0 && cyc >= done_q[0]) begin
            e = done_q.pop_front();
            checkOutput("done_missing", 128'(done), 128'(1));
        end
        while (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            r = rd_q.pop_front();
            checkOutput(r.name, rk_out, r.exp);
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        sched_t      s;
        logic [127:0] k;
        int          idx;

        build_sbox();
        rst = 1'b1; start = 1'b0; key_in = '0; rk_idx = '0;
        tick(); tick();
        checkOutput("reset_busy", 128'(busy), 128'(0));
        checkOutput("reset_done", 128'(done), 128'(0));
        checkOutput("reset_keys_valid", 128'(keys_valid), 128'(0));
        checkOutput("reset_rk_out", rk_out, 128'h0);
        rst = 1'b0;
        tick();

        $display("[TB] FIPS-197 appendix key");
        s = model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
        checkOutput("fips_busy", 128'(busy), 128'(1));
        repeat (10) tick();
        checkOutput("fips_keys_valid", 128'(keys_valid), 128'(1));
        checkOutput("fips_busy_end", 128'(busy), 128'(0));
        read_check(1, 128'ha0fafe1788542cb123a339392a6c7605, "fips_rk1");
        read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "fips_rk10");
        read_check(0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "fips_rk0");
        for (int i = 0; i <= 10; i++) read_check(i, s[i], $sformatf("fips_step_rk%0d", i));
        read_check(15, 128'h0, "idx_out_of_range");

        $display("[TB] restart with keys_valid set, sequential key");
        applyStimulus(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
        checkOutput("restart_busy", 128'(busy), 128'(1));
        checkOutput("restart_keys_valid", 128'(keys_valid), 128'(0));
        repeat (10) tick();
        read_check(10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "seq_rk10");

        $display("[TB] start while busy is ignored");
        k = {$urandom, $urandom, $urandom, $urandom};
        s = model_expand(k);
        applyStimulus(k, 1'b1);
        tick(); tick();
        applyStimulus(~k, 1'b0);
        repeat (7) tick();
        read_check(10, s[10], "ignored_start_rk10");
        read_check(5, s[5], "ignored_start_rk5");

        $display("[TB] reset mid-expansion");
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        done_q.delete();
        checkOutput("abort_busy", 128'(busy), 128'(0));
        checkOutput("abort_done", 128'(done), 128'(0));
        checkOutput("abort_keys_valid", 128'(keys_valid), 128'(0));
        checkOutput("abort_rk_out", rk_out, 128'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("post_reset_busy", 128'(busy), 128'(0));
        end
        read_check(10, 128'h0, "cleared_rk10");
        read_check(0, 128'h0, "cleared_rk0");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        k = {$urandom, $urandom, $urandom, $urandom};
        s = model_expand(k);
        applyStimulus(k, 1'b1);
        repeat (10) tick();
        for (int i = 0; i <= 10; i++) read_check(i, s[i], $sformatf("after_reset_rk%0d", i));

        $display("[TB] random keys");
        for (int n = 0; n < 6; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            s = model_expand(k);
            applyStimulus(k, 1'b1);
            checkOutput("rand_keys_valid_drop", 128'(keys_valid), 128'(0));
            repeat (10) tick();
            checkOutput("rand_keys_valid", 128'(keys_valid), 128'(1));
            for (int j = 0; j < 3; j++) begin
                idx = int'($urandom_range(0, 10));
                read_check(idx, s[idx], $sformatf("rand_rk%0d", idx));
            end
            read_check(int'($urandom_range(11, 15)), 128'h0, "rand_idx_out_of_range");
        end

        repeat (3) tick();
        checkOutput("done_queue_drained", 128'(done_q.size()), 128'(0));
        checkOutput("read_queue_drained", 128'(rd_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
